universal_shift_reg: RTL
========================

# universal_shift_reg

Parametrised successor to the single-bit D flip-flop with clear/preset. It is a WIDTH-bit register with synchronous active-low clear and preset, enable, and an eight-way mode select: hold, parallel load, logical shift left/right, rotate left/right, count up and count down. Serial ports and a wrap flag let instances chain into wider shifters or counters. It is the general storage and shift element for the lab datapaths.

## Interface
- WIDTH, 8: register width in bits; legal range 2 to 64.
- PRESET_VAL, all ones: value loaded by preset. Width is WIDTH.

- clk  input  1  clock; all state changes on its rising edge.
- clear  input  1  reset. Synchronous and active-low; forces q to 0.
- preset  input  1  synchronous, active-low; forces q to PRESET_VAL.
- en  input  1  active-high operation enable.
- mode  input  3  operation select, encoded as listed under Operation.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering the LSB on shift left.
- sin_l  input  1  serial input entering the MSB on shift right.
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1] (combinational from q).
- sout_r  output  1  equals q[0] (combinational from q).
- tc  output  1  registered terminal-count flag.

## Operation
- Priority at each rising edge: clear, then preset, then en, then mode.
- clear==0: q=0 and tc=0, regardless of the value of preset.
- clear==1, preset==0: q=PRESET_VAL and tc=0.
- clear==1, preset==1, en==0: q holds and tc=0.
- clear==1, preset==1, en==1, decoded by mode:
  - 000 HOLD: q holds.
  - 001 LOAD: q=d.
  - 010 SHL: q={q[WIDTH-2:0], sin_r}.
  - 011 SHR: q={sin_l, q[WIDTH-1:1]}.
  - 100 ROL: q={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q={q[0], q[WIDTH-1:1]}.
  - 110 UP: q=q+1, modulo 2^WIDTH.
  - 111 DN: q=q-1, modulo 2^WIDTH.
- tc is set to 1 for exactly one cycle after either of these edges:
  - an UP edge where q was all ones before the edge (wraps to 0);
  - a DN edge where q was 0 before the edge (wraps to all ones).
- tc is 0 after every other edge.
- Arithmetic is unsigned at WIDTH bits. The carry out is not stored anywhere except as tc.
- X or Z on d, sin_r or sin_l propagates into q only in modes that consume that input.
- X on mode while en==1 is a checker error on the bench; the RTL has no defined response.

## Timing
- Reset value on clear: q=0, tc=0. sout_l and sout_r follow q, so both are 0.
- Latency: one clock from an input change to the q update. tc is valid in the same cycle as the q it describes.
- There is no asynchronous path. A clear or preset that pulses between rising edges has no effect.
- clear or preset asserted in the middle of a count or shift sequence takes effect at the next edge. The interrupted operation is discarded and tc is 0.
- Between edges there is no state change. The negative edge is unused.
- Chaining two instances into a 2*WIDTH-bit shifter:
  - For SHL, connect the lower instance's sout_l to the upper instance's sin_r.
  - For SHR, connect the upper instance's sout_r to the lower instance's sin_l.
  - Both instances must use the same clk, clear and mode.
- For a chained counter, drive the upper instance's en from the lower instance's wrap condition. That wrap condition is combinational and must come from a wrapper; tc itself is one cycle late.

## Structure
- Package ureg_pkg holds:
  - the mode encoding, as a 3-bit enum with values MODE_HOLD through MODE_DN;
  - the WIDTH legality bounds.
- Single module; no sub-module is required.
- The next-state function is one combinational always block feeding one clocked always block. That clocked block is the only assignment point for q and tc, with no duplicate edge blocks.

## Test plan
- Clear and preset precedence (WIDTH=8):
  - clear=0, preset=0 → q=0x00, tc=0;
  - clear=1, preset=0 → q=0xFF;
  - clear=0 while preset=0 and en=1, mode=LOAD, d=0x5A → q=0x00.
- Load and hold: LOAD d=0xA5 → q=0xA5. Then en=0 with mode=UP for 3 edges → q stays 0xA5.
- Shift and rotate from q=0x81:
  - SHL with sin_r=0 → 0x02, sout_l was 1 before the edge;
  - reload 0x81, ROL → 0x03;
  - ROR → 0x81;
  - SHR with sin_l=1 → 0xC0.
- Count wrap:
  - from 0xFE, UP for 2 edges → 0xFF with tc=0, then 0x00 with tc=1, then tc=0 on the next HOLD;
  - from 0x00, DN → 0xFF with tc=1.
- Reset mid-operation: counting UP from 0x10, pull clear low for one edge at q=0x13 → next q=0x00, tc=0. Then UP resumes and gives 0x01.
- Width sweep: repeat the shift and wrap scenarios at WIDTH=2 and WIDTH=64.
  - WIDTH=2 from 2'b11, UP → 2'b00 with tc=1.

Source files
------------

// File: rtl/ureg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// the supported register width range.
package ureg_pkg;

  // Operation select, decoded only while en is high.
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DN   = 3'b111
  } mode_t;

  // Legal WIDTH bounds; below 2 the shift slices collapse.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with synchronous active-low clear and preset, enable,
// and eight operations (hold, load, shifts, rotates, up/down count).
// Serial outputs and a registered wrap flag (tc) allow chaining instances.
module universal_shift_reg
  import ureg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("universal_shift_reg: WIDTH out of supported range");
  end

  logic [WIDTH-1:0] q_next;
  logic             tc_next;

  // Serial outputs expose the bits that leave the register on a shift.
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  // Next-state decode below clear: preset, then enable, then mode; tc only
  // flags a count that wraps on this edge.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (!preset) begin
      q_next = PRESET_VAL;
    end else if (en) begin
      case (mode_t'(mode))
        MODE_HOLD: q_next = q;
        MODE_LOAD: q_next = d;
        MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
        MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
        MODE_UP: begin
          q_next  = q + 1'b1;
          tc_next = (q == '1);
        end
        MODE_DN: begin
          q_next  = q - 1'b1;
          tc_next = (q == '0);
        end
        default: q_next = q;
      endcase
    end
  end

  // Single state register; clear has top priority and discards any operation.
  always_ff @(posedge clk) begin
    if (!clear) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= tc_next;
    end
  end

endmodule
